div_unit_iter: RTL

Parametrised iterative integer divider for the execution stage. It serves DIV/DIVU/REM/REMU and their 32-bit word variants (DIVW/DIVUW/REMW/REMUW). It replaces the fixed-width, fixed-latency divider path and adds:
- configurable radix (bits per cycle);
- a shortened iteration count for word ops;
- single-cycle fast paths for divide-by-zero and signed overflow;
- flush via kill_i.

It sits beside the ALU and multiplier, fed by read-register issue and draining to the scalar write-back port.

---
 rtl/div_unit_iter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/div_unit_iter.sv
// Iterative restoring integer divider for DIV/DIVU/REM/REMU and their word variants.
// Retires BPC quotient bits per cycle; divide-by-zero and signed overflow bypass iteration.
module div_unit_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned BPC   = 1,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             kill_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(XLEN / BPC) + 1;
    localparam logic [CW-1:0] NFULL = CW'(XLEN / BPC);
    localparam logic [CW-1:0] NWORD = CW'(32 / BPC);
    localparam int unsigned WSH = XLEN - 32;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_e            state_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   div_q;
    logic [CW-1:0]     cnt_q;
    logic              word_q;
    logic              is_rem_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;

    // Operand preparation and fast-path detection, evaluated on the raw request.
    logic            is_signed, a_neg, b_neg, div_zero, overflow, fast;
    logic [XLEN-1:0] a, b, a_mag, b_mag, min_val, fast_q, fast_r, fast_res, quo_init;

    always_comb begin
        is_signed = ~op_i[0];
        if (word_i) begin
            a       = is_signed ? sext32(src1_i[31:0]) : XLEN'(src1_i[31:0]);
            b       = is_signed ? sext32(src2_i[31:0]) : XLEN'(src2_i[31:0]);
            min_val = sext32(32'h8000_0000);
        end else begin
            a       = src1_i;
            b       = src2_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = is_signed & a[XLEN-1];
        b_neg    = is_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == '0);
        overflow = is_signed && (a == min_val) && (b == '1);
        fast     = div_zero | overflow;
        fast_q   = div_zero ? '1 : a;
        fast_r   = div_zero ? a : '0;
        fast_res = op_i[1] ? fast_r : fast_q;
        if (word_i) fast_res = sext32(fast_res[31:0]);
        // Word dividends start at the top so the last of 32 steps lands the quotient in [31:0].
        quo_init = word_i ? (a_mag << WSH) : a_mag;
    end

    // One iteration step (BPC restoring steps) plus final sign fix-up.
    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] quo_nx, q_fin, r_fin, sel_fin, res_fin;

    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        for (int unsigned i = 0; i < BPC; i++) begin
            rem_nx = {rem_nx[XLEN-1:0], quo_nx[XLEN-1]};
            quo_nx = {quo_nx[XLEN-2:0], 1'b0};
            if (rem_nx >= {1'b0, div_q}) begin
                rem_nx    = rem_nx - {1'b0, div_q};
                quo_nx[0] = 1'b1;
            end
        end
        q_fin   = q_neg_q ? -quo_nx : quo_nx;
        r_fin   = r_neg_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        sel_fin = is_rem_q ? r_fin : q_fin;
        res_fin = word_q ? sext32(sel_fin[31:0]) : sel_fin;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            word_q   <= 1'b0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && !kill_i) begin
                        tag_q    <= tag_i;
                        word_q   <= word_i;
                        is_rem_q <= op_i[1];
                        q_neg_q  <= a_neg ^ b_neg;
                        r_neg_q  <= a_neg;
                        if (fast) begin
                            result_q <= fast_res;
                            state_q  <= StDone;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= quo_init;
                            div_q   <= b_mag;
                            cnt_q   <= word_i ? NWORD : NFULL;
                            state_q <= StIter;
                        end
                    end
                end
                StIter: begin
                    if (kill_i) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_q <= res_fin;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign resp_valid_o = (state_q == StDone) && !kill_i;
    assign result_o     = result_q;
    assign tag_o        = tag_q;

endmodule
